// File: rtl/row_packet_if.sv
// Handshake bundle between the row/col result source, row_packet_tx and the UART transmitter.
// slave = the packetizer side, master = the word source / transmitter side.
interface row_packet_if #(
  parameter int DATA_WIDTH = 136
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  tx_ready;
  logic                  tx_start;
  logic [7:0]            tx_byte;
  logic                  tx_done;
  logic                  err;
  logic                  busy;

  modport slave (
    input  in_data, in_valid, tx_ready,
    output in_ready, tx_start, tx_byte, tx_done, err, busy
  );

  modport master (
    output in_data, in_valid, tx_ready,
    input  in_ready, tx_start, tx_byte, tx_done, err, busy
  );
endinterface

// File: rtl/row_packet_tx.sv
// Serializes one packed sparse row/col word into header, values and indices bytes for the UART.
// Optional trailing XOR checksum byte when ROW_PACKET_CHECKSUM_EN is defined.
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | in_ready high, waiting for a word
// CHECK     | validate nnz, align fields, load counter/byte 0
// ERROR     | one-cycle err pulse, nothing sent
// WAIT_TX   | tx_byte presented, waiting for transmitter idle
// SEND      | one-cycle tx_start
// WAIT_ACK  | waiting for tx_ready to drop
// WAIT_IDLE | waiting for tx_ready to return, then advance
// DONE      | one-cycle tx_done pulse
module row_packet_tx #(
  parameter int MATRIX_N = 4,
  parameter int HEADER   = 1
) (
  input  logic         clk,
  input  logic         resetn,
  row_packet_if.slave  bus
);
  localparam int DATA_WIDTH = HEADER*8 + 32*MATRIX_N;
  localparam int HB         = HEADER*8;
  localparam int FW         = 16*MATRIX_N;
  localparam int CW         = $clog2(HEADER + 4*MATRIX_N + 2);

  typedef enum logic [2:0] {
    IDLE, CHECK, ERROR, WAIT_TX, SEND, WAIT_ACK, WAIT_IDLE, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [HB-1:0] hdr_q, hdr_d;
  logic [FW-1:0] vals_q, vals_d;
  logic [FW-1:0] idx_q, idx_d;
  logic [CW-1:0] nnz_q, nnz_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [7:0]    byte_q, byte_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    csum_nxt;

  logic [CW-1:0] nnz_c, gap, p_nxt, two_n, four_n;
  logic [HB-1:0] hdr_sh;
  logic [FW-1:0] val_sh, idx_sh;
  logic [7:0]    nxt_byte;

  assign nnz_c  = hdr_q[CW-1:0];
  assign gap    = CW'(MATRIX_N) - nnz_c;
  assign two_n  = {nnz_q[CW-2:0], 1'b0};
  assign four_n = {nnz_q[CW-3:0], 2'b00};

  // Byte following the current one; value/index fields are already left-aligned so entry 0 sits on top.
  always_comb begin
    p_nxt    = ptr_q + CW'(1);
    hdr_sh   = hdr_q << {p_nxt, 3'b000};
    val_sh   = vals_q << {p_nxt - CW'(HEADER), 3'b000};
    idx_sh   = idx_q << {p_nxt - CW'(HEADER) - two_n, 3'b000};
    csum_nxt = csum_q ^ byte_q;
    nxt_byte = 8'h00;
    if (p_nxt < CW'(HEADER))                  nxt_byte = hdr_sh[HB-1 -: 8];
    else if (p_nxt < CW'(HEADER) + two_n)     nxt_byte = val_sh[FW-1 -: 8];
    else if (p_nxt < CW'(HEADER) + four_n)    nxt_byte = idx_sh[FW-1 -: 8];
`ifdef ROW_PACKET_CHECKSUM_EN
    else                                      nxt_byte = csum_nxt;
`endif
  end

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    vals_d  = vals_q;
    idx_d   = idx_q;
    nnz_d   = nnz_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    byte_d  = byte_q;
    csum_d  = csum_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          hdr_d   = bus.in_data[DATA_WIDTH-1 -: HB];
          vals_d  = bus.in_data[2*FW-1 -: FW];
          idx_d   = bus.in_data[FW-1:0];
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (hdr_q == '0 || hdr_q > HB'(MATRIX_N)) begin
          state_d = ERROR;
        end else begin
          nnz_d   = nnz_c;
          vals_d  = vals_q << {gap, 4'b0000};
          idx_d   = idx_q << {gap, 4'b0000};
`ifdef ROW_PACKET_CHECKSUM_EN
          cnt_d   = CW'(HEADER) + {nnz_c[CW-3:0], 2'b00} + CW'(1);
`else
          cnt_d   = CW'(HEADER) + {nnz_c[CW-3:0], 2'b00};
`endif
          ptr_d   = '0;
          byte_d  = hdr_q[HB-1 -: 8];
          csum_d  = 8'h00;
          state_d = WAIT_TX;
        end
      end
      ERROR:    state_d = IDLE;
      WAIT_TX:  if (bus.tx_ready) state_d = SEND;
      SEND:     state_d = WAIT_ACK;
      WAIT_ACK: if (!bus.tx_ready) state_d = WAIT_IDLE;
      WAIT_IDLE: begin
        if (bus.tx_ready) begin
          cnt_d   = cnt_q - CW'(1);
          ptr_d   = p_nxt;
          byte_d  = nxt_byte;
          csum_d  = csum_nxt;
          state_d = (cnt_q == CW'(1)) ? DONE : WAIT_TX;
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      vals_q  <= '0;
      idx_q   <= '0;
      nnz_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      byte_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      vals_q  <= vals_d;
      idx_q   <= idx_d;
      nnz_q   <= nnz_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      byte_q  <= byte_d;
      csum_q  <= csum_d;
    end
  end

  // in_ready is held low while reset is asserted, even though the state already reads IDLE.
  assign bus.in_ready = (state_q == IDLE) && resetn;
  assign bus.tx_start = (state_q == SEND);
  assign bus.tx_byte  = byte_q;
  assign bus.tx_done  = (state_q == DONE);
  assign bus.err      = (state_q == ERROR);
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_row_packet_tx.sv
// Randomized bench for row_packet_tx: byte stream compared against a queue-based packet model.
module tb_row_packet_tx;
  localparam int MATRIX_N = 4;
  localparam int HEADER   = 1;
  localparam int DW       = HEADER*8 + 32*MATRIX_N;

  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  row_packet_if #(.DATA_WIDTH(DW)) bus();

  row_packet_tx #(.MATRIX_N(MATRIX_N), .HEADER(HEADER)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bq_t  rxq;
  int   n_start = 0;
  int   n_done  = 0;
  int   n_err   = 0;
  int   acc_cyc[$];
  int   done_cyc[$];
  int   ucnt = 0;
  bit   force_low = 0;
  bit   lat_pend = 0;
  bit   lat_en = 1;
  bit   prev_end = 0;
  int   last_acc = 0;
  logic [7:0] last_byte = 8'h00;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Packet as the receiver expects it, built from the field rules directly.
  function automatic bq_t model(input logic [DW-1:0] w);
    bq_t q;
    int n;
    logic [63:0] v, ix;
    logic [15:0] e;
    logic [7:0]  x;
    n  = int'(w[DW-1 -: 8]);
    v  = w[127:64];
    ix = w[63:0];
    x  = 8'h00;
    if (n == 0 || n > MATRIX_N) return q;
    q.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      e = 16'(v >> (16*(n-1-i)));
      q.push_back(e[15:8]); q.push_back(e[7:0]);
    end
    for (int i = 0; i < n; i++) begin
      e = 16'(ix >> (16*(n-1-i)));
      q.push_back(e[15:8]); q.push_back(e[7:0]);
    end
`ifdef ROW_PACKET_CHECKSUM_EN
    foreach (q[i]) x ^= q[i];
    q.push_back(x);
`endif
    return q;
  endfunction

  function automatic logic [DW-1:0] rand_word(input int nnz);
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    t[DW-1 -: 8] = 8'(nnz);
    return t[DW-1:0];
  endfunction

  // Ideal UART: tx_ready drops after tx_start and returns 10 cycles later.
  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      ucnt = 0;
      lat_pend = 0;
      prev_end = 0;
      bus.tx_ready = !force_low;
    end else begin
      if (prev_end) check_val("rdy_after_end", 32'(bus.in_ready), 32'd1);
      prev_end = bus.tx_done || bus.err;
      if (ucnt > 0) begin
        check_val("byte_hold", 32'(bus.tx_byte), 32'(last_byte));
        ucnt--;
      end
      if (bus.tx_start) begin
        rxq.push_back(bus.tx_byte);
        last_byte = bus.tx_byte;
        n_start++;
        ucnt = 10;
        check_val("busy_in_send", 32'(bus.busy), 32'd1);
        if (lat_pend && lat_en) check_val("latency", 32'(cyc - last_acc), 32'd3);
        lat_pend = 0;
      end
      if (bus.tx_done) begin
        n_done++;
        done_cyc.push_back(cyc);
      end
      if (bus.err) n_err++;
      bus.tx_ready = (ucnt == 0) && !force_low;
    end
  end

  always @(posedge clk) begin
    if (resetn && bus.in_valid && bus.in_ready) begin
      acc_cyc.push_back(cyc);
      last_acc = cyc;
      lat_pend = 1;
    end
  end

  task automatic send(input logic [DW-1:0] w);
    int k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 3000) begin @(negedge clk); k++; end
    if (k >= 3000) check_val("send_timeout", 32'd0, 32'd1);
    #1;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_end(input int base);
    int k = 0;
    while ((n_done + n_err) <= base && k < 3000) begin @(negedge clk); k++; end
    if (k >= 3000) check_val("end_timeout", 32'd0, 32'd1);
  endtask

  task automatic compare_stream(input string tag, input bq_t exp, input int s0, input int d0,
                                input int e0, input int exp_done, input int exp_err);
    check_val({tag, "_nbytes"}, 32'(rxq.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < rxq.size(); i++)
      check_val({tag, "_byte"}, 32'(rxq[i]), 32'(exp[i]));
    check_val({tag, "_starts"}, 32'(n_start - s0), 32'(exp.size()));
    check_val({tag, "_done"}, 32'(n_done - d0), 32'(exp_done));
    check_val({tag, "_err"}, 32'(n_err - e0), 32'(exp_err));
  endtask

  task automatic run_pkt(input string tag, input logic [DW-1:0] w);
    bq_t exp;
    int s0, d0, e0;
    exp = model(w);
    s0 = n_start; d0 = n_done; e0 = n_err;
    rxq.delete();
    send(w);
    wait_end(d0 + e0);
    repeat (2) @(negedge clk);
    if (exp.size() == 0) compare_stream(tag, exp, s0, d0, e0, 0, 1);
    else                 compare_stream(tag, exp, s0, d0, e0, 1, 0);
  endtask

  initial begin
    logic [DW-1:0] w, wb;
    bq_t exp, expb;
    int s0, d0, e0, a0, k;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    repeat (3) @(negedge clk);
    #1;
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check_val("rst_tx_byte",  32'(bus.tx_byte),  32'd0);
    check_val("rst_tx_done",  32'(bus.tx_done),  32'd0);
    check_val("rst_err",      32'(bus.err),      32'd0);
    check_val("rst_busy",     32'(bus.busy),     32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check_val("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_val("post_rst_busy",     32'(bus.busy),     32'd0);

    w = rand_word(2);
    w[95:64] = 32'h1234ABCD;
    w[31:0]  = 32'h00010003;
    run_pkt("plan_nnz2", w);
    check_val("plan_first_byte", 32'(rxq.size() > 0 ? rxq[0] : 8'hxx), 32'h02);

    run_pkt("nnz0", rand_word(0));
    run_pkt("nnz5", rand_word(5));

    // Transmitter stalled before the first byte.
    w = rand_word(4);
    w[127:64] = 64'hFFFF_FFFF_FFFF_FFFF;
    w[63:0]   = 64'h0000_0001_0002_0003;
    exp = model(w);
    s0 = n_start; d0 = n_done; e0 = n_err;
    rxq.delete();
    force_low = 1; lat_en = 0;
    send(w);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      #1 check_val("stall_byte", 32'(bus.tx_byte), 32'(exp[0]));
    end
    check_val("stall_no_start", 32'(n_start - s0), 32'd0);
    force_low = 0;
    wait_end(d0 + e0);
    repeat (2) @(negedge clk);
    lat_en = 1;
    compare_stream("stall", exp, s0, d0, e0, 1, 0);

    // Reset during the 5th byte's WAIT_IDLE.
    s0 = n_start;
    rxq.delete();
    send(rand_word(4));
    k = 0;
    while (n_start - s0 < 5 && k < 3000) begin @(negedge clk); k++; end
    if (k >= 3000) check_val("midrst_timeout", 32'd0, 32'd1);
    repeat (4) @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    check_val("midrst_tx_start", 32'(bus.tx_start), 32'd0);
    check_val("midrst_tx_byte",  32'(bus.tx_byte),  32'd0);
    check_val("midrst_tx_done",  32'(bus.tx_done),  32'd0);
    check_val("midrst_busy",     32'(bus.busy),     32'd0);
    check_val("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    s0 = n_start;
    repeat (5) @(negedge clk);
    #1 resetn = 1'b1;
    repeat (20) @(negedge clk);
    check_val("midrst_no_start", 32'(n_start - s0), 32'd0);
    run_pkt("after_rst_nnz1", rand_word(1));

    // in_valid held high with two queued words.
    w  = rand_word(3);
    wb = rand_word(2);
    exp = model(w);
    expb = model(wb);
    foreach (expb[i]) exp.push_back(expb[i]);
    s0 = n_start; d0 = n_done; e0 = n_err; a0 = acc_cyc.size();
    rxq.delete();
    @(negedge clk);
    #1 bus.in_data = w; bus.in_valid = 1'b1;
    k = 0;
    while (acc_cyc.size() < a0 + 1 && k < 3000) begin @(negedge clk); k++; end
    #1 bus.in_data = wb;
    while (acc_cyc.size() < a0 + 2 && k < 6000) begin @(negedge clk); k++; end
    #1 bus.in_valid = 1'b0;
    if (k >= 6000) check_val("b2b_timeout", 32'd0, 32'd1);
    wait_end(d0 + e0 + 1);
    repeat (2) @(negedge clk);
    compare_stream("b2b", exp, s0, d0, e0, 2, 0);
    if (acc_cyc.size() >= a0 + 2 && done_cyc.size() >= d0 + 1)
      check_val("b2b_accept_cycle", 32'(acc_cyc[a0+1]), 32'(done_cyc[d0] + 1));
    else
      check_val("b2b_events", 32'd0, 32'd1);

    for (int i = 0; i < 16; i++)
      run_pkt("random", rand_word(int'($urandom_range(0, 6))));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end
endmodule

// File: doc/row_packet_tx.md
Name: row_packet_tx

Overview:
- Serializes one packed sparse matrix row/col word into the byte stream consumed by the comm receiver: header (nnz), values, indices.
- Sits between the result memory/datapath, which supplies one packed word per handshake, and the UART transmitter.
- Sends only the nnz valid entries: packet length is HEADER + 4*nnz bytes.

Parameters:
- MATRIX_N, 4, max entries per row/col; values and indices fields are each 16*MATRIX_N bits.
- HEADER, 1, header size in bytes; holds nnz, unsigned, MSB first.
- DATA_WIDTH, HEADER*8+32*MATRIX_N, packed word width (derived, not overridden).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- in_data  in  DATA_WIDTH  packed word {nnz[HEADER*8], values[16*MATRIX_N], indices[16*MATRIX_N]}.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a word.
- tx_ready  in  1  UART transmitter idle.
- tx_start  out  1  start transmitting tx_byte.
- tx_byte  out  8  byte to transmit.
- tx_done  out  1  one-cycle pulse, packet fully sent.
- err  out  1  one-cycle pulse, word rejected.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Interface decided: clock clk; reset resetn, asynchronous, active-low.
- Field layout: the nnz valid entries occupy the least-significant 16*nnz bits of the values and indices fields. Entry 0 is the most significant of these. Bits above 16*nnz are ignored.
- Byte order on the wire:
  - header bytes, MSB first;
  - values entry 0..nnz-1, each high byte then low byte;
  - indices entry 0..nnz-1, same byte order.
- Reset values: in_ready=0 during reset, 1 on the first IDLE cycle after release; tx_start=0, tx_byte=0x00, tx_done=0, err=0, busy=0. All internal registers are cleared and the FSM goes to IDLE.
- Reset mid-packet aborts immediately. No further tx_start is issued, and no resume occurs.
- Accept: word is taken on a clock edge with in_valid && in_ready, into an internal shift register. in_ready=1 only in IDLE.
- FSM states, all outputs Moore from registered state:
  - IDLE: on accept -> CHECK.
  - CHECK: if nnz==0 or nnz>MATRIX_N -> ERROR. Otherwise load byte counter = HEADER+4*nnz and select byte 0 -> WAIT_TX.
  - ERROR: err=1 for one cycle, no bytes sent -> IDLE.
  - WAIT_TX: tx_byte holds the current byte; if tx_ready -> SEND.
  - SEND: tx_start=1 for exactly this one cycle -> WAIT_ACK.
  - WAIT_ACK: wait for tx_ready==0 (transmitter acknowledges) -> WAIT_IDLE.
  - WAIT_IDLE: wait for tx_ready==1. Then decrement the counter and advance the byte pointer. Counter now 0 -> DONE, else -> WAIT_TX.
  - DONE: tx_done=1 for one cycle -> IDLE.
- tx_byte is stable from WAIT_TX entry through WAIT_IDLE exit, and changes only on advance.
- Latency: if tx_ready is held high, the first tx_start occurs 3 cycles after the accept edge (CHECK, WAIT_TX, SEND).
- Byte counter width: clog2(HEADER+4*MATRIX_N+2). No wrap is permitted.
- in_valid asserted while not in IDLE is ignored; no back-to-back accept occurs.
- tx_ready stuck at 0 holds the FSM in WAIT_TX indefinitely, with no timeout.
- nnz wider than the counter range is caught by the >MATRIX_N check before loading.

Optional Feature:
- Macro: ROW_PACKET_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR of every transmitted byte (header, values, indices) is kept.
  - The checksum is cleared in CHECK.
  - One extra byte, the final XOR, is sent after the last index byte, using the same WAIT_TX/SEND/WAIT_ACK/WAIT_IDLE handshake.
  - Counter is loaded with HEADER+4*nnz+1.
  - tx_done follows the checksum byte.
- Undefined: no checksum logic and no extra byte.

Test Plan:
- MATRIX_N=4, HEADER=1, nnz=2, values low 32 bits 0x1234ABCD, indices low 32 bits 0x00010003, ideal UART model (tx_ready drops 1 cycle after tx_start, returns 10 cycles later):
  - bytes 02 12 34 AB CD 00 01 00 03;
  - 9 tx_start pulses;
  - one tx_done after the 9th byte returns tx_ready;
  - first tx_start 3 cycles after accept.
- Same stimulus with ROW_PACKET_CHECKSUM_EN: the 9 bytes above followed by 0x40, then tx_done.
- nnz=0, then separately nnz=5: err pulses once, zero tx_start, in_ready returns to 1 the cycle after ERROR.
- nnz=4, all values 0xFFFF, all indices 0x0000..0x0003, tx_ready held low for 50 cycles before first byte: no tx_start while low; 17 bytes correct afterwards; tx_byte is stable during each hold.
- Deassert resetn during the 5th byte's WAIT_IDLE: outputs immediately take reset values, with no further tx_start. After release, a new nnz=1 packet sends exactly 5 bytes.
- in_valid held high continuously with two queued words: the second word is accepted only on the first IDLE cycle after tx_done; the two packets do not interleave.
